// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: bus widths, ES->MS field offsets, load-type codes.
// The ES->MS bus widens when MS_UNALIGNED_LOAD_EN is defined (adds rt_value for LWL/LWR).
package mem_stage_pkg;

`ifdef MS_UNALIGNED_LOAD_EN
   localparam int ES_TO_MS_BUS_WD = 106;
`else
   localparam int ES_TO_MS_BUS_WD = 74;
`endif
   localparam int MS_TO_WS_BUS_WD = 70;
   localparam int MS_FWD_BUS_WD   = 38;

   localparam int PC_LSB         = 0;
   localparam int ALU_RESULT_LSB = 32;
   localparam int DEST_LSB       = 64;
   localparam int GR_WE_BIT      = 69;
   localparam int RES_FROM_MEM_BIT = 70;
   localparam int LOAD_TYPE_LSB  = 71;
   localparam int RT_VALUE_LSB   = 74;

   typedef enum logic [2:0] {
      LD_W  = 3'd0,
      LD_B  = 3'd1,
      LD_BU = 3'd2,
      LD_H  = 3'd3,
      LD_HU = 3'd4,
      LD_WL = 3'd5,
      LD_WR = 3'd6
   } load_type_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data alignment and extension; reusable by any memory path.
// LWL/LWR merging exists only when MS_UNALIGNED_LOAD_EN is defined.
module load_align
   import mem_stage_pkg::*;
(
   input  load_type_e  load_type,
   input  logic [1:0]  addr,
   input  logic [31:0] mem_word,
   input  logic [31:0] rt_value,
   output logic [31:0] load_data
);

   logic [7:0]  mem_byte [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign mem_byte[gi] = mem_word[8*gi +: 8];
   end

   assign byte_sel = mem_byte[addr];
   assign half_sel = addr[1] ? mem_word[31:16] : mem_word[15:0];

`ifndef MS_UNALIGNED_LOAD_EN
   logic unused_rt;
   assign unused_rt = ^rt_value;
`endif

   always_comb begin
      load_data = mem_word;
      case (load_type)
         LD_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
         LD_BU: load_data = {24'd0, byte_sel};
         LD_H:  load_data = {{16{half_sel[15]}}, half_sel};
         LD_HU: load_data = {16'd0, half_sel};
`ifdef MS_UNALIGNED_LOAD_EN
         // Big end of the merge comes from memory for LWL, little end for LWR.
         LD_WL: begin
            case (addr)
               2'd0:    load_data = {mem_word[7:0],  rt_value[23:0]};
               2'd1:    load_data = {mem_word[15:0], rt_value[15:0]};
               2'd2:    load_data = {mem_word[23:0], rt_value[7:0]};
               default: load_data = mem_word;
            endcase
         end
         LD_WR: begin
            case (addr)
               2'd0:    load_data = mem_word;
               2'd1:    load_data = {rt_value[31:24], mem_word[31:8]};
               2'd2:    load_data = {rt_value[31:16], mem_word[31:16]};
               default: load_data = {rt_value[31:8],  mem_word[31:24]};
            endcase
         end
`endif
         default: load_data = mem_word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, selects/extends load data, feeds WS and decode forwarding.
// Optional LWL/LWR support via MS_UNALIGNED_LOAD_EN.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ws_allowin,
   output logic                        ms_allowin,
   input  logic                        es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus,
   input  logic [31:0]                 data_sram_rdata,
   output logic                        ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0]  ms_to_ws_bus,
   output logic [MS_FWD_BUS_WD-1:0]    ms_fwd_bus
);

   logic                       ms_valid_reg;
   logic                       rdata_vld_reg;
   logic [31:0]                rdata_buf_reg;
   logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_reg;
   logic                       ms_ready_go;
   logic                       ms_accept;

   logic        gr_we;
   logic        res_from_mem;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;
   logic [31:0] rt_value;
   logic [31:0] mem_word;
   logic [31:0] load_data;
   logic [31:0] final_result;

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid_reg || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
   assign ms_accept      = es_to_ms_valid && ms_allowin;

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid_reg  <= 1'b0;
         rdata_vld_reg <= 1'b0;
      end else begin
         if (ms_allowin)
            ms_valid_reg <= es_to_ms_valid;
         // A newly latched instruction must see live SRAM data in its first cycle.
         if (ms_accept)
            rdata_vld_reg <= 1'b0;
         else if (ms_valid_reg && !rdata_vld_reg)
            rdata_vld_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ms_accept)
         es_to_ms_bus_reg <= es_to_ms_bus;
      if (ms_valid_reg && !rdata_vld_reg)
         rdata_buf_reg <= data_sram_rdata;
   end

   assign gr_we        = es_to_ms_bus_reg[GR_WE_BIT];
   assign res_from_mem = es_to_ms_bus_reg[RES_FROM_MEM_BIT];
   assign dest         = es_to_ms_bus_reg[DEST_LSB +: 5];
   assign alu_result   = es_to_ms_bus_reg[ALU_RESULT_LSB +: 32];
   assign pc           = es_to_ms_bus_reg[PC_LSB +: 32];
`ifdef MS_UNALIGNED_LOAD_EN
   assign rt_value     = es_to_ms_bus_reg[RT_VALUE_LSB +: 32];
`else
   assign rt_value     = 32'd0;
`endif

   assign mem_word = rdata_vld_reg ? rdata_buf_reg : data_sram_rdata;

   load_align u_load_align (
      .load_type (load_type_e'(es_to_ms_bus_reg[LOAD_TYPE_LSB +: 3])),
      .addr      (alu_result[1:0]),
      .mem_word  (mem_word),
      .rt_value  (rt_value),
      .load_data (load_data)
   );

   assign final_result = res_from_mem ? load_data : alu_result;
   assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
   assign ms_fwd_bus   = {ms_valid_reg && gr_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, multi-cycle sequences, random vs. reference model.
// Expectations for load types 5/6 follow MS_UNALIGNED_LOAD_EN.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic                       clk;
   logic                       reset;
   logic                       ws_allowin;
   logic                       ms_allowin;
   logic                       es_to_ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
   logic [31:0]                data_sram_rdata;
   logic                       ms_to_ws_valid;
   logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
   logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ws_allowin      (ws_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .data_sram_rdata (data_sram_rdata),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .ms_fwd_bus      (ms_fwd_bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [ES_TO_MS_BUS_WD-1:0] make_bus(
      input logic [2:0] lt, input logic rfm, input logic we, input logic [4:0] dst,
      input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] rt);
      logic [ES_TO_MS_BUS_WD-1:0] b;
      b = '0;
      b[73:71] = lt;
      b[70]    = rfm;
      b[69]    = we;
      b[68:64] = dst;
      b[63:32] = alu;
      b[31:0]  = pc;
`ifdef MS_UNALIGNED_LOAD_EN
      b[105:74] = rt;
`else
      if (rt != 32'd0) b[31:0] = pc; // rt has no slot in the narrow bus
`endif
      return b;
   endfunction

   // Reference load semantics expressed with shifts and masks.
   function automatic logic [31:0] ref_load(input int lt, input logic [1:0] a,
                                            input logic [31:0] m, input logic [31:0] rt);
      logic [31:0] bv, hv, ones;
      bv   = (m >> (8 * a)) & 32'h0000_00FF;
      hv   = (m >> (16 * a[1])) & 32'h0000_FFFF;
      ones = 32'hFFFF_FFFF;
      case (lt)
         1: return bv[7]  ? (bv | 32'hFFFF_FF00) : bv;
         2: return bv;
         3: return hv[15] ? (hv | 32'hFFFF_0000) : hv;
         4: return hv;
`ifdef MS_UNALIGNED_LOAD_EN
         5: return (m << (8 * (3 - a))) | (rt & (ones >> (8 * (a + 1))));
         6: return (m >> (8 * a)) | (rt & ~(ones >> (8 * a)));
`endif
         default: return m;
      endcase
   endfunction

   typedef struct {
      logic [2:0]  lt;
      logic        rfm;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] rt;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Random-phase model state: the slot's contents and the word it saw when it arrived.
   logic        m_valid;
   logic        m_first;
   logic [31:0] m_word;
   logic [2:0]  m_lt;
   logic        m_rfm, m_we;
   logic [4:0]  m_dest;
   logic [31:0] m_alu, m_pc, m_rt;

   initial begin
      vec_t v;
      logic [31:0] res, word, exp_res;
      logic        exp_allow;
      logic [2:0]  r_lt;
      logic        r_rfm, r_we;
      logic [4:0]  r_dest;
      logic [31:0] r_alu, r_pc, r_rt;

      vecs.push_back('{3'd1, 1'b1, 32'h0000_1002, 32'h12F4_5678, 32'h0, 32'hFFFF_FFF4});
      vecs.push_back('{3'd2, 1'b1, 32'h0000_1002, 32'h12F4_5678, 32'h0, 32'h0000_00F4});
      vecs.push_back('{3'd3, 1'b1, 32'h0000_2002, 32'h8001_ABCD, 32'h0, 32'hFFFF_8001});
      vecs.push_back('{3'd4, 1'b1, 32'h0000_2002, 32'h8001_ABCD, 32'h0, 32'h0000_8001});
      vecs.push_back('{3'd3, 1'b1, 32'h0000_2000, 32'h8001_ABCD, 32'h0, 32'hFFFF_ABCD});
      vecs.push_back('{3'd1, 1'b1, 32'h0000_0003, 32'h8000_0000, 32'h0, 32'hFFFF_FF80});
      vecs.push_back('{3'd0, 1'b1, 32'h0000_0003, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF});
      vecs.push_back('{3'd7, 1'b1, 32'h0000_0001, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D});
      vecs.push_back('{3'd1, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678});
      vecs.push_back('{3'd2, 1'b1, 32'h0000_0000, 32'h0000_00FF, 32'h0, 32'h0000_00FF});
      vecs.push_back('{3'd3, 1'b1, 32'h0000_0003, 32'h7FFF_0000, 32'h0, 32'h0000_7FFF});
`ifdef MS_UNALIGNED_LOAD_EN
      vecs.push_back('{3'd5, 1'b1, 32'h0000_0001, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344});
      vecs.push_back('{3'd6, 1'b1, 32'h0000_0002, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_AABB});
      vecs.push_back('{3'd5, 1'b1, 32'h0000_0000, 32'hAABB_CCDD, 32'h1122_3344, 32'hDD22_3344});
      vecs.push_back('{3'd6, 1'b1, 32'h0000_0003, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_33AA});
`else
      vecs.push_back('{3'd5, 1'b1, 32'h0000_0001, 32'hAABB_CCDD, 32'h0, 32'hAABB_CCDD});
      vecs.push_back('{3'd6, 1'b1, 32'h0000_0002, 32'hAABB_CCDD, 32'h0, 32'hAABB_CCDD});
`endif

      // Reset held three cycles with ES offering.
      reset           = 1'b1;
      ws_allowin      = 1'b1;
      es_to_ms_valid  = 1'b1;
      es_to_ms_bus    = make_bus(3'd0, 1'b0, 1'b1, 5'd4, 32'h44, 32'hBFC0_0000, 32'h0);
      data_sram_rdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #2;
         chk("reset_ms_to_ws_valid", ms_to_ws_valid, 1'b0);
         chk("reset_fwd_valid", ms_fwd_bus[37], 1'b0);
         chk("reset_ms_allowin", ms_allowin, 1'b1);
      end
      $display("reset sequence done");
      @(negedge clk);
      reset          = 1'b0;
      es_to_ms_valid = 1'b0;

      // Vector table: offer one cycle, check the following cycle with the vector's SRAM word.
      foreach (vecs[i]) begin
         v = vecs[i];
         @(negedge clk);
         es_to_ms_valid  = 1'b1;
         es_to_ms_bus    = make_bus(v.lt, v.rfm, 1'b1, 5'(i + 1), v.alu, 32'h1000 + 32'(i * 4), v.rt);
         data_sram_rdata = $urandom;
         @(negedge clk);
         es_to_ms_valid  = 1'b0;
         data_sram_rdata = v.rdata;
         #2;
         chk("vec_valid", ms_to_ws_valid, 1'b1);
         chk("vec_result", ms_to_ws_bus[63:32], v.exp);
         chk("vec_fwd", ms_fwd_bus, {1'b1, 5'(i + 1), v.exp});
         $display("vec %0d lt=%0d addr=%h rdata=%h result=%h", i, v.lt, v.alu, v.rdata, ms_to_ws_bus[63:32]);
      end

      // LW held across a 4-cycle WS stall while the SRAM word changes.
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = make_bus(3'd0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h2000, 32'h0);
      @(negedge clk);
      es_to_ms_valid  = 1'b0;
      ws_allowin      = 1'b0;
      data_sram_rdata = 32'hDEAD_BEEF;
      #2;
      chk("stall_c1_result", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
      chk("stall_c1_allowin", ms_allowin, 1'b0);
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         data_sram_rdata = 32'h0;
         #2;
         chk("stall_hold_result", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
         chk("stall_hold_allowin", ms_allowin, 1'b0);
      end
      @(negedge clk);
      ws_allowin = 1'b1;
      #2;
      chk("stall_release_valid", ms_to_ws_valid, 1'b1);
      chk("stall_release_result", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
      chk("stall_release_allowin", ms_allowin, 1'b1);
      @(negedge clk);
      #2;
      chk("stall_drained", ms_to_ws_valid, 1'b0);
      $display("stall sequence result=%h", 32'hDEAD_BEEF);

      // Reset during a stall drops the held instruction.
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = make_bus(3'd0, 1'b1, 1'b1, 5'd8, 32'h200, 32'h3000, 32'h0);
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      ws_allowin     = 1'b0;
      @(negedge clk);
      #2;
      chk("midreset_held", ms_to_ws_valid, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset      = 1'b0;
      ws_allowin = 1'b1;
      #2;
      chk("midreset_dropped", ms_to_ws_valid, 1'b0);
      chk("midreset_fwd", ms_fwd_bus[37], 1'b0);
      $display("mid-stall reset sequence done");

      // Back-to-back ALU op then LW; LW must use live rdata in its first cycle.
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = make_bus(3'd0, 1'b0, 1'b1, 5'd3, 32'h5, 32'h4000, 32'h0);
      @(negedge clk);
      es_to_ms_bus    = make_bus(3'd0, 1'b1, 1'b1, 5'd9, 32'h40, 32'h4004, 32'h0);
      data_sram_rdata = 32'h1111_1111;
      #2;
      chk("b2b_alu_valid", ms_to_ws_valid, 1'b1);
      chk("b2b_alu_fwd", ms_fwd_bus, 38'h23_0000_0005);
      @(negedge clk);
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = 32'hCAFE_F00D;
      #2;
      chk("b2b_lw_valid", ms_to_ws_valid, 1'b1);
      chk("b2b_lw_pc", ms_to_ws_bus[31:0], 32'h4004);
      chk("b2b_lw_fwd", ms_fwd_bus, {1'b1, 5'd9, 32'hCAFE_F00D});
      $display("back-to-back sequence done");
      @(negedge clk);

      // Random traffic against the reference model.
      m_valid = 1'b0;
      m_first = 1'b0;
      m_word  = 32'h0;
      {m_lt, m_rfm, m_we, m_dest, m_alu, m_pc, m_rt} = '0;
      #2;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         reset           = ($urandom_range(0, 49) == 0);
         ws_allowin      = ($urandom_range(0, 2) != 0);
         es_to_ms_valid  = ($urandom_range(0, 3) != 0);
         data_sram_rdata = $urandom;
         r_lt   = 3'($urandom_range(0, 7));
         r_rfm  = 1'($urandom);
         r_we   = 1'($urandom);
         r_dest = 5'($urandom);
         r_alu  = $urandom;
         r_pc   = $urandom;
`ifdef MS_UNALIGNED_LOAD_EN
         r_rt   = $urandom;
`else
         r_rt   = 32'h0;
`endif
         es_to_ms_bus = make_bus(r_lt, r_rfm, r_we, r_dest, r_alu, r_pc, r_rt);
         #2;
         exp_allow = !m_valid || ws_allowin;
         chk("rand_allowin", ms_allowin, exp_allow);
         chk("rand_valid", ms_to_ws_valid, m_valid);
         chk("rand_fwd_valid", ms_fwd_bus[37], m_valid && m_we);
         if (m_valid) begin
            word    = m_first ? data_sram_rdata : m_word;
            exp_res = m_rfm ? ref_load(int'(m_lt), m_alu[1:0], word, m_rt) : m_alu;
            chk("rand_ws_bus", ms_to_ws_bus, {m_we, m_dest, exp_res, m_pc});
            chk("rand_fwd_data", ms_fwd_bus[36:0], {m_dest, exp_res});
            if (ms_to_ws_valid && ws_allowin)
               $display("rand %0d handover pc=%h lt=%0d result=%h", cyc, m_pc, m_lt, exp_res);
         end
         if (reset) begin
            m_valid = 1'b0;
         end else begin
            if (m_valid && m_first) begin
               m_word  = data_sram_rdata;
               m_first = 1'b0;
            end
            if (exp_allow) begin
               m_valid = es_to_ms_valid;
               if (es_to_ms_valid) begin
                  m_first = 1'b1;
                  {m_lt, m_rfm, m_we, m_dest, m_alu, m_pc, m_rt} =
                     {r_lt, r_rfm, r_we, r_dest, r_alu, r_pc, r_rt};
               end
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
